// File: rtl/bram_reg_master_if.sv
// Command, response and BRAM-port signals of the register-bus initiator.
// master: the initiator itself; slave: sequencer plus register-file responder.
interface bram_reg_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_NUM   = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_wr;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  bram_en;
  logic [BYTE_NUM-1:0]   bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_din;
  logic [DATA_WIDTH-1:0] bram_dout;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, bram_dout,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, bram_en, bram_we, bram_addr, bram_din
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, bram_dout,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, bram_en, bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/bram_reg_master.sv
// Single-command initiator for the BRAM-style register bus with registered outputs.
// Define BRAM_REG_MASTER_WR_VERIFY_EN to follow every write with a read-back check.
module bram_reg_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_NUM   = 4,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned VFY_GAP    = 2
) (
  input  logic              clk,
  input  logic              rstn,
  bram_reg_master_if.master bus,
  output logic              busy
);

  localparam int unsigned CntMax = (RD_LAT > VFY_GAP) ? RD_LAT : VFY_GAP;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] RdCnt = CntW'(RD_LAT - 1);
`ifdef BRAM_REG_MASTER_WR_VERIFY_EN
  localparam logic [CntW-1:0] GapCnt = CntW'(VFY_GAP - 1);
`endif

  typedef enum logic [2:0] {
    StIdle, StAcc, StRwait, StGap, StVrd, StVwait, StRsp
  } state_e;

  state_e          state_q;
  logic            wr_q;
  logic [CntW-1:0] cnt_q;
`ifdef BRAM_REG_MASTER_WR_VERIFY_EN
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
`endif

  // Each state's outputs are loaded on the edge that enters it, so the
  // strobe/response is visible for exactly the cycles the state lasts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      wr_q          <= 1'b0;
      cnt_q         <= '0;
`ifdef BRAM_REG_MASTER_WR_VERIFY_EN
      addr_q        <= '0;
      wdata_q       <= '0;
`endif
      busy          <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.bram_en   <= 1'b0;
      bus.bram_we   <= '0;
      bus.bram_addr <= '0;
      bus.bram_din  <= '0;
    end else begin
      bus.bram_en   <= 1'b0;
      bus.bram_we   <= '0;
      bus.bram_addr <= '0;
      bus.bram_din  <= '0;

      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            wr_q          <= bus.cmd_wr;
`ifdef BRAM_REG_MASTER_WR_VERIFY_EN
            addr_q        <= bus.cmd_addr;
            wdata_q       <= bus.cmd_wdata;
`endif
            bus.cmd_ready <= 1'b0;
            busy          <= 1'b1;
            if (bus.cmd_addr[1:0] != 2'b00) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
              state_q       <= StRsp;
            end else begin
              bus.bram_en   <= 1'b1;
              bus.bram_we   <= {BYTE_NUM{bus.cmd_wr}};
              bus.bram_addr <= bus.cmd_addr;
              bus.bram_din  <= bus.cmd_wr ? bus.cmd_wdata : '0;
              state_q       <= StAcc;
            end
          end
        end

        StAcc: begin
          if (wr_q) begin
`ifdef BRAM_REG_MASTER_WR_VERIFY_EN
            cnt_q   <= GapCnt;
            state_q <= StGap;
`else
            bus.rsp_valid <= 1'b1;
            state_q       <= StRsp;
`endif
          end else begin
            cnt_q   <= RdCnt;
            state_q <= StRwait;
          end
        end

        StRwait: begin
          if (cnt_q == '0) begin
            bus.rsp_rdata <= bus.bram_dout;
            bus.rsp_valid <= 1'b1;
            state_q       <= StRsp;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end

`ifdef BRAM_REG_MASTER_WR_VERIFY_EN
        StGap: begin
          if (cnt_q == '0) begin
            bus.bram_en   <= 1'b1;
            bus.bram_addr <= addr_q;
            state_q       <= StVrd;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end

        StVrd: begin
          cnt_q   <= RdCnt;
          state_q <= StVwait;
        end

        StVwait: begin
          if (cnt_q == '0) begin
            bus.rsp_rdata <= bus.bram_dout;
            bus.rsp_err   <= (bus.bram_dout != wdata_q);
            bus.rsp_valid <= 1'b1;
            state_q       <= StRsp;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
`endif

        StRsp: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.cmd_ready <= 1'b1;
            busy          <= 1'b0;
            state_q       <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_reg_master.sv
// Directed bench for bram_reg_master: vector table plus backpressure, reset and
// (when BRAM_REG_MASTER_WR_VERIFY_EN is defined) write-verify sequences.
module tb_bram_reg_master;

  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned BN     = 4;
  localparam int unsigned RdLat  = 1;
  localparam int unsigned VfyGap = 2;

`ifdef BRAM_REG_MASTER_WR_VERIFY_EN
  localparam bit Vfy = 1'b1;
`else
  localparam bit Vfy = 1'b0;
`endif
  // Cycle numbers counted from the handshake edge (cycle 1 follows it).
  localparam int WrRsp = Vfy ? 3 + VfyGap + RdLat : 2;
  localparam int WrEn2 = Vfy ? 2 + VfyGap : 0;
  localparam int RdRsp = 2 + RdLat;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  bram_reg_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_NUM(BN)) bus ();

  bram_reg_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_NUM(BN), .RD_LAT(RdLat), .VFY_GAP(VfyGap)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus),
    .busy (busy)
  );

  // Responder: 16-word memory, unwritten words read as 0xC0DE_00xx.
  logic [31:0] mem [16];
  logic [15:0] written = '0;
  logic [31:0] pipe [RdLat];
  bit          zero_mode = 1'b0;
  logic [3:0]  ridx;
  assign ridx = bus.bram_addr[5:2];

  always @(posedge clk) begin
    if (bus.bram_en) begin
      if (bus.bram_we == 4'hF && !zero_mode) begin
        mem[ridx]     <= bus.bram_din;
        written[ridx] <= 1'b1;
      end
      pipe[0] <= zero_mode ? 32'h0 : (written[ridx] ? mem[ridx] : 32'hC0DE_0000 + {28'h0, ridx});
    end
    for (int i = 1; i < RdLat; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.bram_dout = pipe[RdLat-1];

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          en_cyc;   // 0: no strobe expected
    int          en2_cyc;  // 0: no verify strobe expected
    logic [3:0]  we;
    int          rsp_cyc;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  task automatic run_vec(input string tag, input vec_t v);
    int en_cyc = 0, en2_cyc = 0, en_cnt = 0, rsp_cyc = 0, k = 0;
    logic [3:0] we = '0, we2 = '0;
    logic [31:0] a = '0, d = '0, rd = '0;
    logic er = 1'b0, idle_bad = 1'b0, busy1 = 1'b0, done_ok = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    while (!bus.cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1) busy1 = busy;
      if (bus.bram_en) begin
        en_cnt++;
        if (en_cnt == 1) begin
          en_cyc = c; we = bus.bram_we; a = bus.bram_addr; d = bus.bram_din;
        end else if (en_cnt == 2) begin
          en2_cyc = c; we2 = bus.bram_we;
        end
      end else if (bus.bram_we != '0 || bus.bram_addr != '0 || bus.bram_din != '0) begin
        idle_bad = 1'b1;
      end
      if (rsp_cyc != 0) begin
        done_ok = bus.cmd_ready && !bus.rsp_valid;
        break;
      end
      if (bus.rsp_valid) begin
        rsp_cyc = c; rd = bus.rsp_rdata; er = bus.rsp_err;
      end
    end
    check({tag, " busy"}, 32'(busy1), 32'd1);
    check({tag, " en_cycle"}, 32'(en_cyc), 32'(v.en_cyc));
    check({tag, " en_count"}, 32'(en_cnt), (v.en_cyc == 0) ? 32'd0 : (v.en2_cyc == 0) ? 32'd1 : 32'd2);
    if (v.en_cyc != 0) begin
      check({tag, " we"}, 32'(we), 32'(v.we));
      check({tag, " addr"}, a, v.addr);
      if (v.wr) check({tag, " din"}, d, v.wdata);
    end
    if (v.en2_cyc != 0) begin
      check({tag, " verify_cycle"}, 32'(en2_cyc), 32'(v.en2_cyc));
      check({tag, " verify_we"}, 32'(we2), 32'd0);
    end
    check({tag, " idle_bus"}, 32'(idle_bad), 32'd0);
    check({tag, " rsp_cycle"}, 32'(rsp_cyc), 32'(v.rsp_cyc));
    check({tag, " rdata"}, rd, v.rdata);
    check({tag, " err"}, 32'(er), 32'(v.err));
    check({tag, " ready_after"}, 32'(done_ok), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " ctrl"},
          32'({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.bram_en, busy, bus.bram_we}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}));
    check({tag, " data"}, bus.bram_addr | bus.bram_din | bus.rsp_rdata, 32'h0);
  endtask

  vec_t vecs[8];

  initial begin
    int k;
    logic [31:0] held;
    logic hold_bad;

    vecs[0] = '{1'b1, 32'h0001_0004, 32'hDEAD_BEEF, 1, WrEn2, 4'hF, WrRsp,
                Vfy ? 32'hDEAD_BEEF : 32'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h0001_0004, 32'h0, 1, 0, 4'h0, RdRsp, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b0, 32'h0001_0006, 32'h0, 0, 0, 4'h0, 1, 32'h0, 1'b1};
    vecs[3] = '{1'b1, 32'h0001_0008, 32'h1234_5678, 1, WrEn2, 4'hF, WrRsp,
                Vfy ? 32'h1234_5678 : 32'h0, 1'b0};
    vecs[4] = '{1'b0, 32'h0001_0008, 32'h0, 1, 0, 4'h0, RdRsp, 32'h1234_5678, 1'b0};
    vecs[5] = '{1'b1, 32'h0001_0001, 32'hFFFF_FFFF, 0, 0, 4'h0, 1, 32'h0, 1'b1};
    vecs[6] = '{1'b0, 32'h0001_000C, 32'h0, 1, 0, 4'h0, RdRsp, 32'hC0DE_0003, 1'b0};
    vecs[7] = '{1'b0, 32'h0001_0004, 32'h0, 1, 0, 4'h0, RdRsp, 32'hDEAD_BEEF, 1'b0};

    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Response held off for 5 cycles.
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = 32'h0001_0004;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    k = 1;
    while (!bus.rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("bp rsp_cycle", 32'(k), 32'(RdRsp));
    held = bus.rsp_rdata;
    check("bp rdata", held, 32'hDEAD_BEEF);
    hold_bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_rdata != held || bus.cmd_ready || bus.bram_en) hold_bad = 1'b1;
    end
    check("bp hold", 32'(hold_bad), 32'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp release", 32'({bus.rsp_valid, bus.cmd_ready}), 32'b01);

    // Reset asserted while the read waits on the responder.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = 32'h0001_0008;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("rst_mid strobe", 32'(bus.bram_en), 32'd1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_idle_outputs("rst_mid in");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_mid out");
    run_vec("after_rst", vecs[4]);

`ifdef BRAM_REG_MASTER_WR_VERIFY_EN
    zero_mode = 1'b1;
    run_vec("vfy_bad", '{1'b1, 32'h0001_0008, 32'h1234_5678, 1, WrEn2, 4'hF, WrRsp,
                         32'h0, 1'b1});
    zero_mode = 1'b0;
    run_vec("vfy_good", '{1'b1, 32'h0001_0008, 32'h1234_5678, 1, WrEn2, 4'hF, WrRsp,
                          32'h1234_5678, 1'b0});
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
